// File: rtl/l1_cache.sv
// Direct-mapped, write-back, write-allocate L1 cache with 128-bit lines.
// The CPU side answers hits combinationally; misses evict and refill over pmem.
module l1_cache #(
  parameter int SET_BITS = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [15:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   mem_byte_enable,
  input  logic [15:0]  mem_wdata,
  output logic         mem_resp,
  output logic [15:0]  mem_rdata,
  output logic [15:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int SETS  = 1 << SET_BITS;
  localparam int TAG_W = 12 - SET_BITS;

  typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_ALLOCATE} state_e;

  state_e state_q, state_d;

  logic [SETS-1:0]     valid_q;
  logic [SETS-1:0]     dirty_q;
  logic [TAG_W-1:0]    tag_q  [SETS];
  logic [127:0]        line_q [SETS];

  logic [SET_BITS-1:0] req_index_q, req_index_d;
  logic [TAG_W-1:0]    req_tag_q, req_tag_d;

  logic [SET_BITS-1:0] addr_index;
  logic [TAG_W-1:0]    addr_tag;
  logic [2:0]          addr_word;
  logic [6:0]          word_lsb;
  logic                request;
  logic                hit;
  logic                wr_hit;
  logic                fill_done;
  logic                evict_done;
  logic [15:0]         old_word;
  logic [15:0]         merged_word;
  logic                unused_addr_bit;

  assign addr_index      = mem_address[3+SET_BITS:4];
  assign addr_tag        = mem_address[15:4+SET_BITS];
  assign addr_word       = mem_address[3:1];
  assign word_lsb        = {addr_word, 4'b0000};
  assign unused_addr_bit = mem_address[0];

  assign request    = mem_read | mem_write;
  assign hit        = valid_q[addr_index] && (tag_q[addr_index] == addr_tag);
  // A simultaneous read+write is handled as a write.
  assign wr_hit     = (state_q == S_IDLE) && mem_write && hit;
  assign fill_done  = (state_q == S_ALLOCATE) && pmem_resp;
  assign evict_done = (state_q == S_WRITEBACK) && pmem_resp;

  assign old_word = line_q[addr_index][word_lsb +: 16];

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    assign merged_word[8*gi +: 8] = mem_byte_enable[gi] ? mem_wdata[8*gi +: 8]
                                                         : old_word[8*gi +: 8];
  end

  // State register plus the reset-covered bookkeeping bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      req_index_q <= '0;
      req_tag_q   <= '0;
    end else begin
      state_q     <= state_d;
      req_index_q <= req_index_d;
      req_tag_q   <= req_tag_d;
      if (fill_done) begin
        valid_q[req_index_q] <= 1'b1;
        dirty_q[req_index_q] <= 1'b0;
      end
      if (evict_done) begin
        dirty_q[req_index_q] <= 1'b0;
      end
      if (wr_hit) begin
        dirty_q[addr_index] <= 1'b1;
      end
    end
  end

  // Tag and line storage carry no reset; valid_q guards their contents.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (fill_done) begin
        line_q[req_index_q] <= pmem_rdata;
        tag_q[req_index_q]  <= req_tag_q;
      end else if (wr_hit) begin
        line_q[addr_index][word_lsb +: 16] <= merged_word;
      end
    end
  end

  // Next-state logic; the miss address is latched so a dropped request can finish.
  always_comb begin
    state_d     = state_q;
    req_index_d = req_index_q;
    req_tag_d   = req_tag_q;
    unique case (state_q)
      S_IDLE: begin
        if (request && !hit) begin
          req_index_d = addr_index;
          req_tag_d   = addr_tag;
          state_d     = dirty_q[addr_index] ? S_WRITEBACK : S_ALLOCATE;
        end
      end
      S_WRITEBACK: begin
        if (pmem_resp) state_d = S_ALLOCATE;
      end
      S_ALLOCATE: begin
        if (pmem_resp) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_resp     = 1'b0;
    mem_rdata    = 16'h0000;
    pmem_address = 16'h0000;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_wdata   = 128'h0;
    unique case (state_q)
      S_IDLE: begin
        if (request && hit) begin
          mem_resp  = 1'b1;
          mem_rdata = old_word;
        end
      end
      S_WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q[req_index_q], req_index_q, 4'b0000};
        pmem_wdata   = line_q[req_index_q];
      end
      S_ALLOCATE: begin
        pmem_read    = 1'b1;
        pmem_address = {req_tag_q, req_index_q, 4'b0000};
      end
      default: ;
    endcase
  end

endmodule
